axi_rd_resp_stub: RTL and testbench
===================================

// Module: axi_rd_resp_stub
// PURPOSE
//  - AXI4 read-channel responder (slave end of AR/R). It answers the read bursts that
//    prefetcherTop issues on m_ar_*/m_r_*.
//  - Replaces the full RAM model in prefetcher benches. Data is a deterministic function
//    of beat address, so no write path is needed and every beat is self-checking.
//  - Latency is programmable. Several requests can be outstanding. Responses return in order.
// PARAMETERS
//  ADDR_BITS            16  AR address width (bytes)
//  TID_WIDTH             8  AR/R ID width
//  BURST_LEN_WIDTH       8  arlen width (beats-1)
//  LOG_BLOCK_DATA_BYTES  0  log2 bytes per beat; DATA_BITS = 8<<LOG_BLOCK_DATA_BYTES
//  LOG_QUEUE_SIZE        2  log2 depth of outstanding-request FIFO (default 4 entries)
//  LATENCY_WIDTH         4  width of cfg_latency
//  DATA_SEED             0  XOR mask applied to every data beat (DATA_BITS wide)
// PORTS
//  clk            in   1                  clock, all logic on posedge
//  resetN         in   1                  asynchronous active-low reset
//  s_ar_valid     in   1                  read request valid
//  s_ar_ready     out  1                  request accepted when valid&ready
//  s_ar_addr      in   ADDR_BITS          burst start byte address (INCR)
//  s_ar_len       in   BURST_LEN_WIDTH    beats-1
//  s_ar_id        in   TID_WIDTH          transaction ID
//  s_r_valid      out  1                  read beat valid
//  s_r_ready      in   1                  beat consumed when valid&ready
//  s_r_data       out  DATA_BITS          beat data
//  s_r_last       out  1                  final beat of burst
//  s_r_id         out  TID_WIDTH          ID of the burst being returned
//  cfg_latency    in   LATENCY_WIDTH      extra idle cycles before each burst
//  outstandingCnt out  LOG_QUEUE_SIZE+1   bursts queued or in flight
// BEHAVIOUR
//  - Reset (async, resetN=0): FIFO empty, FSM=IDLE, beat counter=0. Outputs: s_r_valid=0,
//    s_r_last=0, s_r_data=0, s_r_id=0, outstandingCnt=0, s_ar_ready=1.
//    Reset during a burst aborts the burst. No further beats of that burst are sent.
//  - AR: s_ar_ready = !full (registered from FIFO state; no same-cycle bypass while full).
//    On handshake push {addr,len,id}. When full, a pop in the same cycle does not raise ready.
//  - FSM:
//    IDLE : FIFO non-empty -> load latCnt=cfg_latency (sampled here only) -> WAIT.
//    WAIT : latCnt==0 -> BURST with beat=0; else latCnt--.
//    BURST: s_r_valid=1. On a beat handshake, beat++.
//           On a handshake with beat==len: pop the FIFO, beat=0. Then go to WAIT (reloading
//           latCnt) if entries remain, else IDLE.
//  - Latency: AR handshake on edge E0 with FIFO empty -> first s_r_valid after edge
//    E0+cfg_latency+2. Subsequent beats are back-to-back while s_r_ready=1.
//  - Beat address = (head.addr + (beat<<LOG_BLOCK_DATA_BYTES)) mod 2^ADDR_BITS
//    (wraps at top of space).
//  - s_r_data = beat address zero-extended/truncated to DATA_BITS, XOR DATA_SEED.
//  - s_r_last = (beat==head.len). s_r_id = head.id.
//  - data/last/id are driven from registered state. While s_r_valid=1 and s_r_ready=0, all
//    R outputs hold stable. s_r_valid never drops without a handshake.
//  - outstandingCnt = FIFO occupancy. It includes the burst in flight until its last beat
//    handshakes. It is max 2^LOG_QUEUE_SIZE.
//  - Simultaneous push and last-beat pop: the count is unchanged and both take effect.
// CONFIGURATION
//  - RD_STUB_STALL_EN defined: an 8-bit LFSR (x^8+x^6+x^5+x^4+1, reset 8'hA5) steps every
//    cycle. In BURST, a beat not yet presented is withheld (s_r_valid=0) on cycles with
//    lfsr[0]=1. Once s_r_valid=1 it holds until the handshake, and the AXI stability rule is
//    kept.
//  - RD_STUB_STALL_EN undefined: no LFSR. s_r_valid=1 throughout BURST.
// TESTING
//  1. Reset, then release -> s_ar_ready=1, s_r_valid=0, outstandingCnt=0.
//  2. addr=0x0EEF len=2 id=5, cfg_latency=0, s_r_ready=1 -> first beat 2 cycles after AR;
//     data 0xEF,0xF0,0xF1; s_r_last on beat 3 only; s_r_id=5.
//  3. Same request, cfg_latency=3, s_r_ready=0 for 5 cycles after s_r_valid rises ->
//     first beat 5 cycles after AR; data stays 0xEF, valid stays 1; then 0xF0,0xF1 follow.
//  4. s_r_ready=0, issue 5 ARs (ids 1..5) -> 4 accepted, outstandingCnt=4, s_ar_ready=0.
//     Then s_r_ready=1 -> bursts return in id order 1..4, then id 5 is accepted.
//  5. addr=0xFFFF len=1 -> data 0xFF then 0x00 (address wrap), s_r_last on the 2nd beat.
//  6. resetN=0 mid-burst (after beat 1 of len=3) -> s_r_valid=0 immediately,
//     outstandingCnt=0. After release, a new request returns correct data from beat 0.

Source files
------------

// File: rtl/axi_rd_resp_stub.sv
// -----------------------------------------------------------------------------
// axi_rd_resp_stub
//   AXI4 read-channel responder (slave side of AR/R) used in place of a full RAM
//   model. Each returned beat carries a deterministic function of its own byte
//   address, so the consumer can check every beat without a write path.
//   Requests are queued in a small FIFO, several can be outstanding, and bursts
//   are returned in order after a programmable number of idle cycles.
//
// Ports
//   clk            in   clock, all logic on the rising edge
//   resetN         in   asynchronous active-low reset (aborts any burst in flight)
//   s_ar_valid     in   read request valid
//   s_ar_ready     out  request accepted on valid&ready (registered, low when full)
//   s_ar_addr      in   burst start byte address (INCR)
//   s_ar_len       in   beats-1
//   s_ar_id        in   transaction ID
//   s_r_valid      out  read beat valid
//   s_r_ready      in   beat consumed on valid&ready
//   s_r_data       out  beat address (truncated/extended) XOR DATA_SEED
//   s_r_last       out  final beat of burst
//   s_r_id         out  ID of the burst being returned
//   cfg_latency    in   idle cycles inserted before each burst
//   outstandingCnt out  bursts queued or in flight
//
// Build option
//   RD_STUB_STALL_EN : when defined, an 8-bit LFSR randomly withholds beats that
//                      have not yet been presented (valid, once raised, holds).
// -----------------------------------------------------------------------------
module axi_rd_resp_stub #(
  parameter int ADDR_BITS            = 16,
  parameter int TID_WIDTH            = 8,
  parameter int BURST_LEN_WIDTH      = 8,
  parameter int LOG_BLOCK_DATA_BYTES = 0,
  parameter int LOG_QUEUE_SIZE       = 2,
  parameter int LATENCY_WIDTH        = 4,
  parameter int DATA_BITS            = 8 << LOG_BLOCK_DATA_BYTES,
  parameter logic [DATA_BITS-1:0] DATA_SEED = {DATA_BITS{1'b0}}
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        s_ar_valid,
  output logic                        s_ar_ready,
  input  logic [ADDR_BITS-1:0]        s_ar_addr,
  input  logic [BURST_LEN_WIDTH-1:0]  s_ar_len,
  input  logic [TID_WIDTH-1:0]        s_ar_id,
  output logic                        s_r_valid,
  input  logic                        s_r_ready,
  output logic [DATA_BITS-1:0]        s_r_data,
  output logic                        s_r_last,
  output logic [TID_WIDTH-1:0]        s_r_id,
  input  logic [LATENCY_WIDTH-1:0]    cfg_latency,
  output logic [LOG_QUEUE_SIZE:0]     outstandingCnt
);

  localparam int QDEPTH = 1 << LOG_QUEUE_SIZE;
  localparam int CW     = LOG_QUEUE_SIZE + 1;

  localparam logic [CW-1:0]              CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0]              CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]              CNT_FULL  = CNT_ONE << LOG_QUEUE_SIZE;
  localparam logic [LOG_QUEUE_SIZE-1:0]  PTR_ONE   = {{(LOG_QUEUE_SIZE-1){1'b0}}, 1'b1};
  localparam logic [LATENCY_WIDTH-1:0]   LAT_ZERO  = {LATENCY_WIDTH{1'b0}};
  localparam logic [LATENCY_WIDTH-1:0]   LAT_ONE   = {{(LATENCY_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [BURST_LEN_WIDTH-1:0] BEAT_ZERO = {BURST_LEN_WIDTH{1'b0}};
  localparam logic [BURST_LEN_WIDTH-1:0] BEAT_ONE  = {{(BURST_LEN_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  // Data for one beat: byte address of the beat (wrapping in the address space)
  // resized to the data width and scrambled with the seed.
  function automatic logic [DATA_BITS-1:0] beat_data(
    input logic [ADDR_BITS-1:0]       base,
    input logic [BURST_LEN_WIDTH-1:0] beat
  );
    logic [ADDR_BITS-1:0] beat_addr;
    beat_addr = base + (ADDR_BITS'(beat) << LOG_BLOCK_DATA_BYTES);
    return DATA_BITS'(beat_addr) ^ DATA_SEED;
  endfunction

  // Request FIFO storage
  logic [ADDR_BITS-1:0]       fifo_addr_q [QDEPTH];
  logic [BURST_LEN_WIDTH-1:0] fifo_len_q  [QDEPTH];
  logic [TID_WIDTH-1:0]       fifo_id_q   [QDEPTH];

  logic [LOG_QUEUE_SIZE-1:0]  wr_ptr_q, wr_ptr_d;
  logic [LOG_QUEUE_SIZE-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]              count_q, count_d;
  logic                       ar_ready_q, ar_ready_d;

  state_t                     state_q, state_d;
  logic [LATENCY_WIDTH-1:0]   lat_q, lat_d;
  logic [BURST_LEN_WIDTH-1:0] beat_q, beat_d;
  logic                       r_valid_q, r_valid_d;
  logic [DATA_BITS-1:0]       r_data_q, r_data_d;
  logic                       r_last_q, r_last_d;
  logic [TID_WIDTH-1:0]       r_id_q, r_id_d;

  logic                       push_s;
  logic                       pop_s;
  logic                       present_s;
  logic                       remain_s;
  logic [BURST_LEN_WIDTH-1:0] beat_inc_s;
  logic [ADDR_BITS-1:0]       head_addr_s;
  logic [BURST_LEN_WIDTH-1:0] head_len_s;
  logic [TID_WIDTH-1:0]       head_id_s;

  assign push_s      = s_ar_valid & ar_ready_q;
  assign head_addr_s = fifo_addr_q[rd_ptr_q];
  assign head_len_s  = fifo_len_q[rd_ptr_q];
  assign head_id_s   = fifo_id_q[rd_ptr_q];
  assign beat_inc_s  = beat_q + BEAT_ONE;
  // Another burst is waiting once the current one pops, counting a same-cycle push.
  assign remain_s    = (count_q > CNT_ONE) | push_s;

`ifdef RD_STUB_STALL_EN
  logic [7:0] lfsr_q, lfsr_d;

  // LFSR next value, taps x^8+x^6+x^5+x^4+1
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // LFSR register, free-running
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Registered valid is decided from the LFSR value of the cycle it applies to.
  assign present_s = ~lfsr_d[0];
`else
  assign present_s = 1'b1;
`endif

  // Response FSM: latency countdown, beat sequencing and R output registers
  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    beat_d    = beat_q;
    r_valid_d = r_valid_q;
    r_data_d  = r_data_q;
    r_last_d  = r_last_q;
    r_id_d    = r_id_q;
    pop_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (count_q != CNT_ZERO) begin
          state_d = ST_WAIT;
          lat_d   = cfg_latency;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (lat_q == LAT_ZERO) begin
          state_d   = ST_BURST;
          beat_d    = BEAT_ZERO;
          r_data_d  = beat_data(head_addr_s, BEAT_ZERO);
          r_last_d  = (head_len_s == BEAT_ZERO);
          r_id_d    = head_id_s;
          r_valid_d = present_s;
        end else begin
          lat_d = lat_q - LAT_ONE;
        end
      end
      ST_BURST: begin
        if (r_valid_q && s_r_ready) begin
          if (beat_q == head_len_s) begin
            pop_s     = 1'b1;
            beat_d    = BEAT_ZERO;
            r_valid_d = 1'b0;
            r_last_d  = 1'b0;
            if (remain_s) begin
              state_d = ST_WAIT;
              lat_d   = cfg_latency;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            beat_d    = beat_inc_s;
            r_data_d  = beat_data(head_addr_s, beat_inc_s);
            r_last_d  = (beat_inc_s == head_len_s);
            r_valid_d = present_s;
          end
        end else if (!r_valid_q) begin
          // Beat not yet presented: may still be withheld this cycle.
          r_valid_d = present_s;
        end else begin
          // Presented beat holds until the handshake.
          r_valid_d = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        r_valid_d = 1'b0;
        r_last_d  = 1'b0;
      end
    endcase
  end

  // FIFO pointer, occupancy and AR ready next-state
  always_comb begin
    wr_ptr_d   = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d   = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    count_d    = count_q + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};
    // Ready follows registered occupancy: a pop while full raises it one cycle later.
    ar_ready_d = (count_d != CNT_FULL);
  end

  // FIFO storage write on AR handshake
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_addr_q[wr_ptr_q] <= s_ar_addr;
      fifo_len_q[wr_ptr_q]  <= s_ar_len;
      fifo_id_q[wr_ptr_q]   <= s_ar_id;
    end
  end

  // State, pointer and output registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_ptr_q   <= {LOG_QUEUE_SIZE{1'b0}};
      rd_ptr_q   <= {LOG_QUEUE_SIZE{1'b0}};
      count_q    <= CNT_ZERO;
      ar_ready_q <= 1'b1;
      state_q    <= ST_IDLE;
      lat_q      <= LAT_ZERO;
      beat_q     <= BEAT_ZERO;
      r_valid_q  <= 1'b0;
      r_data_q   <= {DATA_BITS{1'b0}};
      r_last_q   <= 1'b0;
      r_id_q     <= {TID_WIDTH{1'b0}};
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ar_ready_q <= ar_ready_d;
      state_q    <= state_d;
      lat_q      <= lat_d;
      beat_q     <= beat_d;
      r_valid_q  <= r_valid_d;
      r_data_q   <= r_data_d;
      r_last_q   <= r_last_d;
      r_id_q     <= r_id_d;
    end
  end

  assign s_ar_ready     = ar_ready_q;
  assign s_r_valid      = r_valid_q;
  assign s_r_data       = r_data_q;
  assign s_r_last       = r_last_q;
  assign s_r_id         = r_id_q;
  assign outstandingCnt = count_q;

endmodule

// File: tb/tb_axi_rd_resp_stub.sv
// Bench for axi_rd_resp_stub (default parameters, stall option off).
// A reference model expands every accepted request into its list of expected
// beats; the R channel is scored against that list in order. Occupancy, AR
// ready, first-beat latency and R stability under backpressure are also scored.
module tb_axi_rd_resp_stub;

  logic        clk = 1'b0;
  logic        resetN;
  logic        s_ar_valid;
  logic        s_ar_ready;
  logic [15:0] s_ar_addr;
  logic [7:0]  s_ar_len;
  logic [7:0]  s_ar_id;
  logic        s_r_valid;
  logic        s_r_ready;
  logic [7:0]  s_r_data;
  logic        s_r_last;
  logic [7:0]  s_r_id;
  logic [3:0]  cfg_latency;
  logic [2:0]  outstandingCnt;

  always #5 clk = ~clk;

  axi_rd_resp_stub dut (
    .clk(clk), .resetN(resetN),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr),
    .s_ar_len(s_ar_len), .s_ar_id(s_ar_id),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_data(s_r_data),
    .s_r_last(s_r_last), .s_r_id(s_r_id),
    .cfg_latency(cfg_latency), .outstandingCnt(outstandingCnt)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [7:0] id;
  } beat_t;

  int    n_tests = 0;
  int    n_fail  = 0;
  beat_t exp_q[$];
  int    model_cnt = 0;
  int    cyc = 0;
  int    first_due = -1;
  bit    hs_ar, hs_r;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: inputs are already driven (we sit at a negedge). Scores the
  // handshakes of the coming edge and the outputs seen at the next negedge.
  task automatic tick();
    bit    prev_hold;
    beat_t prev_beat;
    beat_t b;
    int    cnt_before;
    logic [15:0] ba;
    hs_ar      = s_ar_valid && s_ar_ready;
    hs_r       = s_r_valid && s_r_ready;
    prev_hold  = s_r_valid && !s_r_ready;
    prev_beat  = {s_r_data, s_r_last, s_r_id};
    cnt_before = model_cnt;
    @(posedge clk);
    cyc++;
    if (hs_r) begin
      if (exp_q.size() == 0) begin
        chk("r_unexpected_beat", 32'd1, 32'd0);
      end else begin
        b = exp_q.pop_front();
        chk("r_data", 32'(prev_beat.data), 32'(b.data));
        chk("r_last", 32'(prev_beat.last), 32'(b.last));
        chk("r_id",   32'(prev_beat.id),   32'(b.id));
        if (b.last) model_cnt--;
      end
    end
    if (hs_ar) begin
      if (cnt_before == 0) first_due = cyc + int'(cfg_latency) + 2;
      for (int i = 0; i <= int'(s_ar_len); i++) begin
        ba = s_ar_addr + 16'(i);
        b.data = ba[7:0];
        b.last = (i == int'(s_ar_len));
        b.id   = s_ar_id;
        exp_q.push_back(b);
      end
      model_cnt++;
    end
    @(negedge clk);
    chk("outstanding_cnt", 32'(outstandingCnt), 32'(model_cnt));
    chk("ar_ready", 32'(s_ar_ready), (model_cnt < 4) ? 32'd1 : 32'd0);
    if (prev_hold) begin
      chk("r_valid_hold", 32'(s_r_valid), 32'd1);
      chk("r_stable", 32'({s_r_data, s_r_last, s_r_id}), 32'(prev_beat));
    end
    if (first_due >= 0 && (s_r_valid || cyc >= first_due)) begin
      chk("first_beat_cycle", s_r_valid ? 32'(cyc) : 32'hFFFF_FFFF, 32'(first_due));
      first_due = -1;
    end
  endtask

  task automatic send_ar(input logic [15:0] a, input logic [7:0] l,
                         input logic [7:0] i, input int budget);
    int n = 0;
    s_ar_valid = 1'b1;
    s_ar_addr  = a;
    s_ar_len   = l;
    s_ar_id    = i;
    do begin
      tick();
      n++;
    end while (!hs_ar && n < budget);
    if (!hs_ar) chk("ar_accept_timeout", 32'd0, 32'd1);
    s_ar_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    int mode;
    resetN      = 1'b0;
    s_ar_valid  = 1'b0;
    s_ar_addr   = 16'h0000;
    s_ar_len    = 8'h00;
    s_ar_id     = 8'h00;
    s_r_ready   = 1'b0;
    cfg_latency = 4'd0;
    repeat (3) @(negedge clk);
    chk("in_reset_r_valid", 32'(s_r_valid), 32'd0);
    chk("in_reset_ar_ready", 32'(s_ar_ready), 32'd1);
    resetN = 1'b1;
    @(negedge clk);
    chk("rst_ar_ready", 32'(s_ar_ready), 32'd1);
    chk("rst_r_valid",  32'(s_r_valid), 32'd0);
    chk("rst_cnt",      32'(outstandingCnt), 32'd0);
    chk("rst_r_last",   32'(s_r_last), 32'd0);
    chk("rst_r_data",   32'(s_r_data), 32'd0);
    chk("rst_r_id",     32'(s_r_id), 32'd0);

    // Zero latency, consumer always ready
    cfg_latency = 4'd0;
    s_r_ready   = 1'b1;
    send_ar(16'h0EEF, 8'd2, 8'd5, 4);
    drain(40);

    // Latency 3 with backpressure right after valid rises
    cfg_latency = 4'd3;
    s_r_ready   = 1'b0;
    send_ar(16'h0EEF, 8'd2, 8'd5, 4);
    n = 0;
    while (!s_r_valid && n < 20) begin
      tick();
      n++;
    end
    chk("lat3_valid_seen", 32'(s_r_valid), 32'd1);
    chk("lat3_first_data", 32'(s_r_data), 32'hEF);
    repeat (5) tick();
    s_r_ready = 1'b1;
    drain(40);

    // Fill the queue, fifth request stalls until space frees
    cfg_latency = 4'd0;
    s_r_ready   = 1'b0;
    for (int k = 1; k <= 4; k++) send_ar(16'(k * 256), 8'd1, 8'(k), 4);
    s_ar_valid = 1'b1;
    s_ar_addr  = 16'h0500;
    s_ar_len   = 8'd1;
    s_ar_id    = 8'd5;
    repeat (6) tick();
    chk("full_cnt",   32'(outstandingCnt), 32'd4);
    chk("full_ready", 32'(s_ar_ready), 32'd0);
    s_r_ready = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!hs_ar && n < 40);
    if (!hs_ar) chk("fifth_ar_timeout", 32'd0, 32'd1);
    s_ar_valid = 1'b0;
    drain(80);

    // Address wrap at the top of the space
    cfg_latency = 4'd1;
    send_ar(16'hFFFF, 8'd1, 8'd7, 4);
    drain(40);

    // Reset in the middle of a burst
    cfg_latency = 4'd0;
    send_ar(16'h0040, 8'd3, 8'd9, 4);
    n = 0;
    while (exp_q.size() > 3 && n < 20) begin
      tick();
      n++;
    end
    chk("mid_burst_reached", 32'(exp_q.size()), 32'd3);
    resetN = 1'b0;
    #1;
    chk("rst_mid_r_valid", 32'(s_r_valid), 32'd0);
    chk("rst_mid_cnt",     32'(outstandingCnt), 32'd0);
    exp_q.delete();
    model_cnt = 0;
    first_due = -1;
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    send_ar(16'h1234, 8'd2, 8'd3, 4);
    drain(40);

    // Randomized traffic
    mode = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) mode = int'($urandom_range(0, 2));
      case (mode)
        0:       s_r_ready = 1'b1;
        1:       s_r_ready = ($urandom_range(0, 1) == 1);
        default: s_r_ready = ($urandom_range(0, 5) == 0);
      endcase
      if (model_cnt == 0 && !s_ar_valid) cfg_latency = 4'($urandom_range(0, 6));
      if (!s_ar_valid && $urandom_range(0, 3) == 0) begin
        s_ar_valid = 1'b1;
        s_ar_addr  = 16'($urandom);
        s_ar_len   = 8'($urandom_range(0, 5));
        s_ar_id    = 8'($urandom);
      end
      tick();
      if (hs_ar) s_ar_valid = 1'b0;
    end
    s_ar_valid = 1'b0;
    s_r_ready  = 1'b1;
    drain(400);
    chk("final_cnt", 32'(outstandingCnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
